amcx_rxfif_unpack: RTL and testbench

//  Downstream consumer of the RX FIFO fabric read port. Pops 32-bit words tagged sof/eof/be/err.
//  Re-emits each frame as a valid/ready byte stream (tdata/tkeep/tlast).

---
 rtl/amcx_rxfif_unpack.sv | 279 +++++++++++++++++++++++++++
 tb/tb_amcx_rxfif_unpack.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amcx_rxfif_unpack.sv
// amcx_rxfif_unpack: pops tagged RX FIFO words, re-emits frames as a byte stream plus one status per frame.
// Optional length limit (MAX_BYTES) enabled by defining AMCX_RXUNPK_MAXLEN_EN.
module amcx_rxfif_unpack #(
  parameter int MAX_BYTES = 1522,
  parameter int CNT_W     = 16
) (
  input  logic             rx_fab_clk,
  input  logic             rx_fab_rst_n,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [31:0]      fifo_data,
  input  logic             fifo_sof,
  input  logic             fifo_eof,
  input  logic [1:0]       fifo_be,
  input  logic             fifo_err,
  input  logic             enable,
  output logic [31:0]      m_tdata,
  output logic [3:0]       m_tkeep,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             sts_valid,
  input  logic             sts_ready,
  output logic [CNT_W-1:0] sts_len,
  output logic             sts_err,
  output logic             sts_trunc,
  output logic [CNT_W-1:0] orphan_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eof;
    logic [1:0]  be;
    logic        err;
  } word_t;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    DISC,
    STAT
  } state_t;

`ifdef AMCX_RXUNPK_MAXLEN_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [CNT_W:0] MAX_L = (CNT_W+1)'(MAX_BYTES);

  state_t state, state_n;

  logic       run;
  logic       inflight;
  logic [1:0] occ;
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  word_t      mem [3];

  word_t      in_w;
  word_t      head;
  logic       buf_empty;
  logic       head_v;
  logic       consume;
  logic       push;
  logic       pop_buf;
  logic [2:0] level;
  logic       out_free;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // With the buffer empty the word arriving from the FIFO is
  // consumed directly, giving the two-cycle pop-to-beat latency.
  assign in_w      = {fifo_data, fifo_sof, fifo_eof, fifo_be, fifo_err};
  assign buf_empty = (occ == 2'd0);
  assign head_v    = buf_empty ? inflight : 1'b1;
  assign head      = buf_empty ? in_w : mem[rd_ptr];
  assign push      = inflight && !(buf_empty && consume);
  assign pop_buf   = consume && !buf_empty;
  assign level     = 3'(occ) + 3'(inflight) - 3'(consume);
  assign out_free  = !m_tvalid || m_tready;

  assign fifo_rd_en = run && !fifo_empty
                   && !(state == IDLE && !enable)
                   && (level < 3'd3);

  always_ff @(posedge rx_fab_clk or negedge rx_fab_rst_n) begin
    if (!rx_fab_rst_n) begin
      run      <= 1'b0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
    end else begin
      run      <= 1'b1;
      inflight <= fifo_rd_en;
      occ      <= occ + 2'(push) - 2'(pop_buf);
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop_buf)
        rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge rx_fab_clk) begin
    if (push)
      mem[wr_ptr] <= in_w;
  end

  logic [3:0] hkeep;
  logic [2:0] hbytes;

  always_comb begin
    hkeep  = 4'b1111;
    hbytes = 3'd4;
    if (head.eof) begin
      unique case (head.be)
        2'd1: begin hkeep = 4'b0001; hbytes = 3'd1; end
        2'd2: begin hkeep = 4'b0011; hbytes = 3'd2; end
        2'd3: begin hkeep = 4'b0111; hbytes = 3'd3; end
        default: ;
      endcase
    end
  end

  logic [CNT_W-1:0] len, len_n, len_add;
  logic [CNT_W:0]   sum;
  logic             over;

  assign sum     = {1'b0, len} + (CNT_W+1)'(hbytes);
  assign len_add = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  assign over    = LIMIT_EN && (sum > MAX_L);

  logic             emit;
  logic             load;
  logic [31:0]      ld_data;
  logic [3:0]       ld_keep;
  logic             ld_last;
  logic             cap;
  logic [CNT_W-1:0] cap_len;
  logic             cap_err;
  logic             cap_trunc;
  logic             orph_inc;
  logic             sts_set;

  always_comb begin
    state_n   = state;
    emit      = 1'b0;
    consume   = 1'b0;
    load      = 1'b0;
    ld_data   = head.data;
    ld_keep   = hkeep;
    ld_last   = 1'b0;
    len_n     = len;
    cap       = 1'b0;
    cap_len   = len;
    cap_err   = 1'b0;
    cap_trunc = 1'b0;
    orph_inc  = 1'b0;
    sts_set   = 1'b0;

    unique case (state)
      IDLE: begin
        if (head_v && enable) begin
          if (!head.sof) begin
            consume  = 1'b1;
            orph_inc = 1'b1;
          end else begin
            emit = out_free;
          end
        end
      end
      FRAME: begin
        if (head_v && out_free) begin
          if (head.sof) begin
            // Missing eof: close with a null beat, keep the sof word.
            load    = 1'b1;
            ld_data = '0;
            ld_keep = 4'b0000;
            ld_last = 1'b1;
            cap     = 1'b1;
            cap_err = 1'b1;
            state_n = STAT;
          end else begin
            emit = 1'b1;
          end
        end
      end
      DISC: begin
        if (head_v) begin
          consume = 1'b1;
          if (head.eof)
            state_n = STAT;
        end
      end
      STAT: begin
        sts_set = !sts_valid && out_free;
        if (sts_valid && sts_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (emit) begin
      consume = 1'b1;
      load    = 1'b1;
      if (over) begin
        ld_data   = '0;
        ld_keep   = 4'b0000;
        ld_last   = 1'b1;
        cap       = 1'b1;
        cap_err   = 1'b1;
        cap_trunc = 1'b1;
        state_n   = head.eof ? STAT : DISC;
      end else begin
        ld_last = head.eof;
        len_n   = len_add;
        if (head.eof) begin
          cap     = 1'b1;
          cap_len = len_add;
          cap_err = head.err;
          state_n = STAT;
        end else begin
          state_n = FRAME;
        end
      end
    end

    if (cap)
      len_n = '0;
  end

  always_ff @(posedge rx_fab_clk or negedge rx_fab_rst_n) begin
    if (!rx_fab_rst_n) begin
      state      <= IDLE;
      len        <= '0;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tlast    <= 1'b0;
      sts_valid  <= 1'b0;
      sts_len    <= '0;
      sts_err    <= 1'b0;
      sts_trunc  <= 1'b0;
      orphan_cnt <= '0;
      bad_cnt    <= '0;
    end else begin
      state <= state_n;
      len   <= len_n;
      if (load) begin
        m_tvalid <= 1'b1;
        m_tdata  <= ld_data;
        m_tkeep  <= ld_keep;
        m_tlast  <= ld_last;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (sts_set)
        sts_valid <= 1'b1;
      else if (sts_ready)
        sts_valid <= 1'b0;
      if (cap) begin
        sts_len   <= cap_len;
        sts_err   <= cap_err;
        sts_trunc <= cap_trunc;
      end
      if (orph_inc && orphan_cnt != '1)
        orphan_cnt <= orphan_cnt + 1'b1;
      if (sts_valid && sts_ready && sts_err && bad_cnt != '1)
        bad_cnt <= bad_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_amcx_rxfif_unpack.sv
// tb_amcx_rxfif_unpack: FIFO model + scoreboard bench for amcx_rxfif_unpack.
// Define AMCX_RXUNPK_MAXLEN_EN to also exercise the 64-byte limit.
module tb_amcx_rxfif_unpack;

`ifdef AMCX_RXUNPK_MAXLEN_EN
  localparam bit LIM  = 1'b1;
  localparam int MAXB = 64;
`else
  localparam bit LIM  = 1'b0;
  localparam int MAXB = 1522;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [31:0] fifo_data = '0;
  logic        fifo_sof = 1'b0;
  logic        fifo_eof = 1'b0;
  logic [1:0]  fifo_be = '0;
  logic        fifo_err = 1'b0;
  logic        enable = 1'b1;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        sts_valid;
  logic        sts_ready = 1'b0;
  logic [15:0] sts_len;
  logic        sts_err;
  logic        sts_trunc;
  logic [15:0] orphan_cnt;
  logic [15:0] bad_cnt;

  always #5 clk = ~clk;

  amcx_rxfif_unpack #(
    .MAX_BYTES(MAXB),
    .CNT_W(16)
  ) dut (
    .rx_fab_clk(clk),
    .rx_fab_rst_n(rst_n),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data),
    .fifo_sof(fifo_sof),
    .fifo_eof(fifo_eof),
    .fifo_be(fifo_be),
    .fifo_err(fifo_err),
    .enable(enable),
    .m_tdata(m_tdata),
    .m_tkeep(m_tkeep),
    .m_tlast(m_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .sts_valid(sts_valid),
    .sts_ready(sts_ready),
    .sts_len(sts_len),
    .sts_err(sts_err),
    .sts_trunc(sts_trunc),
    .orphan_cnt(orphan_cnt),
    .bad_cnt(bad_cnt)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        sof;
    logic        eof;
    logic [1:0]  be;
    logic        err;
  } fw_t;

  fw_t         fifo_q [$];
  logic [36:0] exp_b [$];
  logic [17:0] exp_s [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_pops = 0;
  int exp_bad = 0;
  int exp_orph = 0;
  int t_pop = -1;
  int t_val = -1;
  int t_last = -1;
  int hold_cnt = 0;
  bit lat_arm = 1'b0;
  bit tready_rand = 1'b0;
  bit sts_slow = 1'b0;
  bit sts_pending = 1'b0;
  bit hold_b = 1'b0;
  bit hold_s = 1'b0;
  logic [36:0] held_b;
  logic [17:0] held_s;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input bit sof,
                           input bit eof, input logic [1:0] be,
                           input bit err);
    fifo_q.push_back({d, sof, eof, be, err});
  endtask

  // Queue one frame and its expected beats/status.
  task automatic frame(input int nbytes, input bit err);
    int nw;
    int len;
    bit done;
    bit bad;
    nw = (nbytes + 3) / 4;
    len = 0;
    done = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < nw; i++) begin
      int b;
      logic [31:0] d;
      logic [3:0] k;
      bit last;
      last = (i == nw - 1);
      b = last ? nbytes - 4 * i : 4;
      d = $urandom;
      if (b < 4)
        d = d & (32'hFFFF_FFFF >> (8 * (4 - b)));
      k = 4'hF >> (4 - b);
      push_word(d, i == 0, last, 2'(b % 4), err && last);
      if (!done) begin
        if (LIM && len + b > MAXB) begin
          exp_b.push_back({32'h0, 4'h0, 1'b1});
          exp_s.push_back({16'(len), 1'b1, 1'b1});
          bad = 1'b1;
          done = 1'b1;
        end else begin
          len += b;
          exp_b.push_back({d, k, last});
          if (last) begin
            exp_s.push_back({16'(len), err, 1'b0});
            bad = err;
          end
        end
      end
    end
    if (bad)
      exp_bad++;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((fifo_q.size() + exp_b.size() + exp_s.size()) != 0
           && i < budget) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    check("drain_left",
          64'(fifo_q.size() + exp_b.size() + exp_s.size()), 64'd0);
  endtask

  always @(posedge clk) begin : fifo_model
    fw_t w;
    if (fifo_rd_en) begin
      n_pops++;
      if (lat_arm && t_pop < 0)
        t_pop = cyc;
      check("fifo_overread", 64'(fifo_q.size() != 0), 64'd1);
      if (fifo_q.size() != 0) begin
        w = fifo_q.pop_front();
        {fifo_data, fifo_sof, fifo_eof, fifo_be, fifo_err} <= w;
      end
    end
    fifo_empty <= (fifo_q.size() == 0);
    cyc++;
  end

  always @(negedge clk) begin : monitor
    if (rst_n) begin
      m_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sts_valid) begin
        sts_ready = !sts_slow || hold_cnt >= 10;
        hold_cnt++;
      end else begin
        sts_ready = 1'b0;
        hold_cnt = 0;
      end
      if (hold_b)
        check("beat_hold", 64'({m_tvalid, m_tdata, m_tkeep, m_tlast}),
              64'({1'b1, held_b}));
      hold_b = m_tvalid && !m_tready;
      held_b = {m_tdata, m_tkeep, m_tlast};
      if (hold_s)
        check("sts_hold", 64'({sts_valid, sts_len, sts_err, sts_trunc}),
              64'({1'b1, held_s}));
      hold_s = sts_valid && !sts_ready;
      held_s = {sts_len, sts_err, sts_trunc};
      if (lat_arm && m_tvalid && t_val < 0)
        t_val = cyc;
      if (m_tvalid && m_tready) begin
        check("beat_before_sts", 64'(sts_pending), 64'd0);
        check("beat_expected", 64'(exp_b.size() != 0), 64'd1);
        if (exp_b.size() != 0)
          check("beat", 64'({m_tdata, m_tkeep, m_tlast}),
                64'(exp_b.pop_front()));
        if (m_tlast) begin
          sts_pending = 1'b1;
          if (lat_arm && t_last < 0)
            t_last = cyc;
        end
      end
      if (sts_valid && sts_ready) begin
        check("sts_expected", 64'(exp_s.size() != 0), 64'd1);
        if (exp_s.size() != 0)
          check("sts", 64'({sts_len, sts_err, sts_trunc}),
                64'(exp_s.pop_front()));
        sts_pending = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d [5];
    int p0;

    // 64B frame queued while reset is held: no pops allowed yet.
    lat_arm = 1'b1;
    frame(64, 1'b0);
    repeat (4) @(negedge clk);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_stream", 64'({m_tvalid, m_tlast, m_tkeep, m_tdata}), 64'd0);
    check("rst_sts", 64'({sts_valid, sts_err, sts_trunc, sts_len}), 64'd0);
    check("rst_cnt", 64'({orphan_cnt, bad_cnt}), 64'd0);
    rst_n = 1'b1;
    drain(400);
    check("latency", 64'(t_val - t_pop), 64'd2);
    check("throughput", 64'(t_last - t_val), 64'd15);
    lat_arm = 1'b0;
    check("bad_cnt_64b", 64'(bad_cnt), 64'(exp_bad));

    frame(61, 1'b1);
    drain(400);
    check("bad_cnt_61b", 64'(bad_cnt), 64'(exp_bad));

    push_word($urandom, 1'b0, 1'b0, 2'd0, 1'b0);
    push_word($urandom, 1'b0, 1'b1, 2'd0, 1'b0);
    exp_orph += 2;
    frame(8, 1'b0);
    drain(400);
    check("orphan_cnt", 64'(orphan_cnt), 64'(exp_orph));

    // sof,w,w,sof,eof(be=2): null terminator then a 6-byte frame.
    for (int i = 0; i < 5; i++)
      d[i] = $urandom;
    d[4] = d[4] & 32'h0000_FFFF;
    push_word(d[0], 1'b1, 1'b0, 2'd0, 1'b0);
    push_word(d[1], 1'b0, 1'b0, 2'd0, 1'b0);
    push_word(d[2], 1'b0, 1'b0, 2'd0, 1'b0);
    push_word(d[3], 1'b1, 1'b0, 2'd0, 1'b0);
    push_word(d[4], 1'b0, 1'b1, 2'd2, 1'b0);
    exp_b.push_back({d[0], 4'hF, 1'b0});
    exp_b.push_back({d[1], 4'hF, 1'b0});
    exp_b.push_back({d[2], 4'hF, 1'b0});
    exp_b.push_back({32'h0, 4'h0, 1'b1});
    exp_s.push_back({16'd12, 1'b1, 1'b0});
    exp_b.push_back({d[3], 4'hF, 1'b0});
    exp_b.push_back({d[4], 4'h3, 1'b1});
    exp_s.push_back({16'd6, 1'b0, 1'b0});
    exp_bad++;
    drain(400);
    check("bad_cnt_noeof", 64'(bad_cnt), 64'(exp_bad));

    frame(3, 1'b0);
    frame(4, 1'b1);
    frame(1, 1'b0);
    drain(400);

    enable = 1'b0;
    repeat (2) @(negedge clk);
    p0 = n_pops;
    frame(12, 1'b0);
    repeat (8) @(negedge clk);
    check("en0_pops", 64'(n_pops - p0), 64'd0);
    check("en0_valid", 64'(m_tvalid), 64'd0);
    enable = 1'b1;
    drain(400);

    tready_rand = 1'b1;
    sts_slow = 1'b1;
    for (int i = 0; i < 6; i++)
      frame($urandom_range(1, 40), 1'($urandom_range(0, 1)));
    drain(4000);
    tready_rand = 1'b0;
    sts_slow = 1'b0;
    check("bad_cnt_rand", 64'(bad_cnt), 64'(exp_bad));

`ifdef AMCX_RXUNPK_MAXLEN_EN
    frame(100, 1'b0);
    frame(20, 1'b0);
    drain(800);
    check("bad_cnt_trunc", 64'(bad_cnt), 64'(exp_bad));
`endif

    check("orphan_final", 64'(orphan_cnt), 64'(exp_orph));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
